// File: rtl/motor_pkg.sv
// Shared types and the psw encoding for the motor ramp sequencer.
package motor_pkg;

   typedef enum logic [1:0] {
      OFF = 2'd0,
      L25 = 2'd1,
      L50 = 2'd2,
      L75 = 2'd3
   } level_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      RAMP_DOWN = 3'd2,
      DWELL     = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam logic [2:0] PSW_OFF = 3'b000;

   // Level 0 is always 000. Forward codes are 001..011.
   // Reverse codes are 100..110. Code 111 is never produced.
   function automatic logic [2:0] psw_encode(input level_t lv, input logic dir);
      logic [2:0] code;
      if (lv == OFF)
         code = PSW_OFF;
      else if (!dir)
         code = {1'b0, lv};
      else
         code = 3'b011 + {1'b0, lv};
      return code;
   endfunction

endpackage

// File: rtl/motor_ramp_ctrl_step_timer.sv
// Loadable down-counter shared by the step and dwell phases.
// The counter stops at zero and never wraps.
module step_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // A load takes priority over a decrement. The count holds once it reaches zero.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Speed/direction ramp sequencer that drives the psw select input of dc_motor.
// Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is registered. It is high only in IDLE or HOLD. An active estop overrides
// any command presented on the same edge, so that command is dropped.
module motor_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int STEP_CYCLES  = 1000,
   parameter int DWELL_CYCLES = 5000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       estop,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_level,
   input  logic       cmd_dir,
   output logic [2:0] psw,
   output logic [1:0] level_cur,
   output logic       dir_cur,
   output logic       at_target,
   output logic [2:0] state_dbg
);

   localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_V = CNT_W'(DWELL_CYCLES - 1);

   state_t           state_q, state_n;
   level_t           level_q, level_n, tl_q, tl_n;
   logic             dir_q, dir_n, td_q, td_n;
   logic             ready_q, at_q;
   logic [2:0]       psw_q;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0] tmr_val;
   logic             accept;
   level_t           cmd_lv;

   assign accept = cmd_valid && ready_q;
   assign cmd_lv = level_t'(cmd_level);

   step_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state logic and timer control. estop overrides every other input.
   always_comb begin
      state_n  = state_q;
      level_n  = level_q;
      dir_n    = dir_q;
      tl_n     = tl_q;
      td_n     = td_q;
      tmr_load = 1'b0;
      tmr_val  = STEP_V;
      tmr_dec  = 1'b0;
      if (estop) begin
         state_n  = DWELL;
         level_n  = OFF;
         tl_n     = OFF;
         td_n     = 1'b0;
         tmr_load = 1'b1;
         tmr_val  = DWELL_V;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  tl_n = cmd_lv;
                  td_n = cmd_dir;
                  if (cmd_lv != OFF) begin
                     state_n  = RAMP_UP;
                     dir_n    = cmd_dir;
                     tmr_load = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (accept) begin
                  tl_n = cmd_lv;
                  td_n = cmd_dir;
                  // A reversal always ramps through zero first.
                  if ((cmd_lv < level_q) || ((cmd_dir != dir_q) && (level_q != OFF))) begin
                     state_n  = RAMP_DOWN;
                     tmr_load = 1'b1;
                  end else if (cmd_lv > level_q) begin
                     state_n  = RAMP_UP;
                     tmr_load = 1'b1;
                  end
               end
            end
            RAMP_UP: begin
               tmr_dec = 1'b1;
               if (tmr_zero) begin
                  level_n = level_t'(level_q + 2'd1);
                  if (level_n == tl_q)
                     state_n = HOLD;
                  else
                     tmr_load = 1'b1;
               end
            end
            RAMP_DOWN: begin
               tmr_dec = 1'b1;
               if (tmr_zero) begin
                  level_n = level_t'(level_q - 2'd1);
                  if (level_n == OFF) begin
                     state_n  = DWELL;
                     tmr_load = 1'b1;
                     tmr_val  = DWELL_V;
                  end else if ((level_n == tl_q) && (td_q == dir_q)) begin
                     state_n = HOLD;
                  end else begin
                     tmr_load = 1'b1;
                  end
               end
            end
            DWELL: begin
               tmr_dec = 1'b1;
               if (tmr_zero) begin
                  if (tl_q == OFF) begin
                     state_n = IDLE;
                  end else begin
                     state_n  = RAMP_UP;
                     dir_n    = td_q;
                     tmr_load = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               level_n = OFF;
            end
         endcase
      end
   end

   // State register. All outputs are registered from next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         level_q <= OFF;
         dir_q   <= 1'b0;
         tl_q    <= OFF;
         td_q    <= 1'b0;
         psw_q   <= PSW_OFF;
         ready_q <= 1'b1;
         at_q    <= 1'b1;
      end else begin
         state_q <= state_n;
         level_q <= level_n;
         dir_q   <= dir_n;
         tl_q    <= tl_n;
         td_q    <= td_n;
         psw_q   <= psw_encode(level_n, dir_n);
         ready_q <= (state_n == IDLE) || (state_n == HOLD);
         at_q    <= (level_n == tl_n) && ((dir_n == td_n) || (level_n == OFF));
      end
   end

   assign psw       = psw_q;
   assign level_cur = level_q;
   assign dir_cur   = dir_q;
   assign at_target = at_q;
   assign cmd_ready = ready_q;
   assign state_dbg = state_q;

endmodule
